// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial front end. Accepts WIDTH-bit words over a
//               valid/ready handshake and shifts them out one bit per clock
//               on a registered serial line. Back-to-back words stream with
//               no idle gap between frames.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: SERIALIZER_PARITY_EN
//   When defined, each frame is followed by one even-parity bit (XOR of the
//   data bits) and frames become WIDTH+1 cycles long.
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   data_in    in   WIDTH  parallel word, sampled on an accepted handshake
//   data_valid in   1      upstream has a word on data_in
//   data_ready out  1      serializer can accept a word this cycle
//   out        out  1      serial bit stream (registered)
//   busy       out  1      a frame is in flight
//   frame_done out  1      pulse while the final bit of a frame is on out
// ============================================================================
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`else
    // Counter value on the cycle before the last data bit; frame_done is
    // registered, so it is set one edge ahead of the bit it marks.
    localparam logic [CW-1:0] c_penult = CW'(WIDTH - 2);
`endif

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_zero = '0;
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_frame_done;
    logic             w_frame_done_nxt;
    logic             w_accept;
    logic             w_last_bit;

    // Bit selection / shift direction for the loaded word and the register.
    logic             w_first_bit;
    logic [WIDTH-1:0] w_load_shifted;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shreg_shifted;

`ifdef SERIALIZER_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == c_last);

`ifdef SERIALIZER_PARITY_EN
    assign data_ready = !reset && ((r_state == S_IDLE) || (r_state == S_PAR));
`else
    assign data_ready = !reset && ((r_state == S_IDLE) || w_last_bit);
`endif

    assign w_accept   = data_valid && data_ready;
    assign busy       = (r_state != S_IDLE);
    assign out        = r_out;
    assign frame_done = r_frame_done;

    // The first bit goes straight to the output register at the accept edge;
    // the shift register then holds the word already advanced by one position,
    // so its leading bit is always the next one to send.
    always_comb begin
        if (MSB_FIRST) begin
            w_first_bit     = data_in[WIDTH-1];
            w_load_shifted  = data_in << 1;
            w_next_bit      = r_shreg[WIDTH-1];
            w_shreg_shifted = r_shreg << 1;
        end else begin
            w_first_bit     = data_in[0];
            w_load_shifted  = data_in >> 1;
            w_next_bit      = r_shreg[0];
            w_shreg_shifted = r_shreg >> 1;
        end
    end

    // Next-state / next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shreg_nxt      = r_shreg;
        w_out_nxt        = r_out;
        w_frame_done_nxt = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        w_par_nxt        = r_par;
`endif

        if (w_accept) begin
            // Load takes priority: this is also the gapless reload path from
            // the final bit of the previous frame.
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = c_zero;
            w_shreg_nxt = w_load_shifted;
            w_out_nxt   = w_first_bit;
`ifdef SERIALIZER_PARITY_EN
            w_par_nxt   = ^data_in;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (r_cnt != c_last) begin
                        w_cnt_nxt   = r_cnt + c_one;
                        w_shreg_nxt = w_shreg_shifted;
                        w_out_nxt   = w_next_bit;
`ifndef SERIALIZER_PARITY_EN
                        w_frame_done_nxt = (r_cnt == c_penult);
`endif
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        w_state_nxt      = S_PAR;
                        w_out_nxt        = r_par;
                        w_frame_done_nxt = 1'b1;
`else
                        w_state_nxt = S_IDLE;
                        w_out_nxt   = IDLE_LEVEL;
                        w_cnt_nxt   = c_zero;
                        w_shreg_nxt = '0;
`endif
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                S_PAR: begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = IDLE_LEVEL;
                    w_cnt_nxt   = c_zero;
                    w_shreg_nxt = '0;
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = IDLE_LEVEL;
                    w_cnt_nxt   = c_zero;
                end
            endcase
        end
    end

    // State and output registers. Reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= c_zero;
            r_shreg      <= '0;
            r_out        <= IDLE_LEVEL;
            r_frame_done <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_out        <= w_out_nxt;
            r_frame_done <= w_frame_done_nxt;
`ifdef SERIALIZER_PARITY_EN
            r_par        <= w_par_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Self-checking bench for bit_serializer. Drives one MSB-first
//               and one LSB-first instance from the same stimulus and checks
//               both against hand-computed bit sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_m;   // MSB-first instance bits, first bit in [7]
        logic [7:0] seq_l;   // LSB-first instance bits, first bit in [7]
        logic       par;     // even parity of data
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready_m, out_m, busy_m, fd_m;
    logic       ready_l, out_l, busy_l, fd_l;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs [6];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_m),
        .out        (out_m),
        .busy       (busy_m),
        .frame_done (fd_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_l),
        .out        (out_l),
        .busy       (busy_l),
        .frame_done (fd_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int k);
        logic [7:0] s;
        s = seq;
        if (k < 8) return s[7-k];
        return par;
    endfunction

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, " out_m"},   out_m,   1'b0);
        check({tag, " out_l"},   out_l,   1'b0);
        check({tag, " busy_m"},  busy_m,  1'b0);
        check({tag, " busy_l"},  busy_l,  1'b0);
        check({tag, " fd_m"},    fd_m,    1'b0);
        check({tag, " fd_l"},    fd_l,    1'b0);
        check({tag, " ready_m"}, ready_m, exp_ready);
        check({tag, " ready_l"}, ready_l, exp_ready);
    endtask

    // Check one cycle of a frame in flight (called #1 after the edge).
    task automatic check_bit(input string tag, input vec_t v, input int k);
        check($sformatf("%s k%0d out_m", tag, k), out_m, exp_bit(v.seq_m, v.par, k));
        check($sformatf("%s k%0d out_l", tag, k), out_l, exp_bit(v.seq_l, v.par, k));
        check($sformatf("%s k%0d fd_m", tag, k), fd_m, logic'(k == FRAME-1));
        check($sformatf("%s k%0d fd_l", tag, k), fd_l, logic'(k == FRAME-1));
        check($sformatf("%s k%0d busy_m", tag, k), busy_m, 1'b1);
        check($sformatf("%s k%0d ready_m", tag, k), ready_m, logic'(k == FRAME-1));
        check($sformatf("%s k%0d ready_l", tag, k), ready_l, logic'(k == FRAME-1));
    endtask

    // Single frame; while busy, data_valid toggles with junk data that must
    // be ignored. Valid is dropped in the final cycle so no new frame starts.
    task automatic send_frame(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        data_in    = v.data;
        data_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < FRAME; k++) begin
            data_valid = (k < FRAME-1) ? logic'(k % 2 == 1) : 1'b0;
            data_in    = 8'($urandom);
            check_bit(tag, v, k);
            @(posedge clk); #1;
        end
        check_idle({tag, " after"}, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vff, v00;
        //            data   seq_m  seq_l  par
        vecs[0] = '{8'hB5, 8'hB5, 8'hAD, 1'b1};
        vecs[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
        vecs[5] = '{8'hC1, 8'hC1, 8'h83, 1'b1};
        vff = vecs[2];
        v00 = vecs[3];

        reset      = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        #1;
        check_idle("post-reset", 1'b1);

        for (int i = 0; i < 6; i++) send_frame(vecs[i], i);

        // Back-to-back: valid held high across the boundary, FF then 00.
        @(negedge clk);
        data_in    = 8'hFF;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h00;
        for (int k = 0; k < FRAME; k++) begin
            check_bit("b2b-ff", vff, k);
            @(posedge clk); #1;
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k == FRAME-1) data_valid = 1'b0;
            check_bit("b2b-00", v00, k);
            @(posedge clk); #1;
        end
        check_idle("b2b after", 1'b1);

        // Reset during the 4th bit of 8'hAA.
        @(negedge clk);
        data_in    = 8'hAA;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_bit("rst-aa", '{8'hAA, 8'hAA, 8'h55, 1'b0}, k);
            @(posedge clk); #1;
        end
        check("rst-aa k3 out_m", out_m, 1'b0);
        check("rst-aa k3 out_l", out_l, 1'b1);
        reset      = 1'b1;
        data_valid = 1'b1;
        #1;
        check("rst-aa ready_m during reset", ready_m, 1'b0);
        check("rst-aa ready_l during reset", ready_l, 1'b0);
        @(posedge clk); #1;
        check_idle("rst-aa in reset", 1'b0);
        reset      = 1'b0;
        data_valid = 1'b0;
        #1;
        check_idle("rst-aa released", 1'b1);
        @(posedge clk); #1;
        check_idle("rst-aa settled", 1'b1);

        // A normal frame still works after the abort.
        send_frame(vecs[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
